// File: rtl/vga_pkg.sv
// Shared VGA drawing constants and types.
// Holds the START-button box geometry and colours (MENU_BTN_*) and the
// button FSM state type used by draw_menu_button.
package vga_pkg;

    // Box geometry, inclusive pixel coordinates.
    localparam logic [10:0] MENU_BTN_X0     = 11'd412;
    localparam logic [10:0] MENU_BTN_X1     = 11'd611;
    localparam logic [10:0] MENU_BTN_Y0     = 11'd300;
    localparam logic [10:0] MENU_BTN_Y1     = 11'd359;
    localparam logic [10:0] MENU_BTN_BORDER = 11'd6;

    // Interior (fill) bounds, derived from the outer box and border width.
    localparam logic [10:0] MENU_BTN_IX0 = MENU_BTN_X0 + MENU_BTN_BORDER;
    localparam logic [10:0] MENU_BTN_IX1 = MENU_BTN_X1 - MENU_BTN_BORDER;
    localparam logic [10:0] MENU_BTN_IY0 = MENU_BTN_Y0 + MENU_BTN_BORDER;
    localparam logic [10:0] MENU_BTN_IY1 = MENU_BTN_Y1 - MENU_BTN_BORDER;

    // Colours.
    localparam logic [11:0] MENU_BTN_BORDER_RGB = 12'hf_a_5;
    localparam logic [11:0] MENU_BTN_FILL_RGB   = 12'h2_2_2;
    localparam logic [11:0] MENU_BTN_FLASH_RGB  = 12'hf_f_f;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLINK = 2'd1,
        ACK   = 2'd2,
        DONE  = 2'd3
    } btn_state_t;

endpackage

// File: rtl/vga_if.sv
// VGA pixel stream bundle passed between draw stages.
// Fields: hcount/vcount (11 b), hsync, vsync, hblnk, vblnk, rgb (12 b).
// Modports: in (consumer side), out (producer side).
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_menu_button_edge_rise.sv
// Registered rising-edge detector.
// Ports: clk, rst (sync, active high), d (level in), rise (d & ~previous d).
// RESET_VAL sets the previous-value register on reset; 1 suppresses an
// edge for an input already high when reset is released.
module edge_rise #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= RESET_VAL;
        else     prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/draw_menu_button.sv
// Blinking START button overlay for the menu / game-over screens.
// Ports:
//   clk, rst      pixel clock, synchronous active-high reset
//   state         game state; button active only for 0 (menu) or 6 (game over)
//   btn_start     debounced start button level
//   start_ack     one-cycle pulse when the acknowledge flash completes
//   vga_btn_in    VGA stream from draw_menu
//   vga_btn_out   VGA stream to the next stage (1-cycle registered)
module draw_menu_button
    import vga_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned ACK_FRAMES   = 24,
    parameter int unsigned ACK_TOGGLE   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic       btn_start,
    output logic       start_ack,
    vga_if.in          vga_btn_in,
    vga_if.out         vga_btn_out
);

    localparam int unsigned CNT_MAX = (BLINK_FRAMES > ACK_FRAMES) ? BLINK_FRAMES : ACK_FRAMES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_FRAMES - 1);
    localparam logic [CNT_W-1:0] TOGGLE_DIV = CNT_W'(ACK_TOGGLE);

    btn_state_t       btn_st;
    logic [CNT_W-1:0] frame_cnt;
    logic             visible;
    logic             tick;
    logic             press;
    logic             active;
    logic             in_box;
    logic             on_border;
    logic             draw;
    logic [11:0]      rgb_nxt;

    edge_rise #(.RESET_VAL(1'b0)) u_vblnk_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (vga_btn_in.vblnk),
        .rise (tick)
    );

    // Resets high so a button held through reset never counts as a press.
    edge_rise #(.RESET_VAL(1'b1)) u_start_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (btn_start),
        .rise (press)
    );

    assign active = (state == 3'd0) || (state == 3'd6);

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_st    <= OFF;
            frame_cnt <= '0;
            visible   <= 1'b1;
            start_ack <= 1'b0;
        end else begin
            start_ack <= 1'b0;
            // Leaving the menu states overrides everything, including the
            // final ACK tick, so no acknowledge escapes in that cycle.
            if (!active) begin
                btn_st <= OFF;
            end else begin
                case (btn_st)
                    OFF: begin
                        btn_st    <= BLINK;
                        frame_cnt <= '0;
                        visible   <= 1'b1;
                    end
                    BLINK: begin
                        if (press) begin
                            btn_st    <= ACK;
                            frame_cnt <= '0;
                            visible   <= 1'b1;
                        end else if (tick) begin
                            if (frame_cnt == BLINK_LAST) begin
                                visible   <= ~visible;
                                frame_cnt <= '0;
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                    end
                    ACK: begin
                        if (tick) begin
                            if (frame_cnt == ACK_LAST) begin
                                btn_st    <= DONE;
                                start_ack <= 1'b1;
                            end else begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        in_box = (vga_btn_in.hcount >= MENU_BTN_X0) && (vga_btn_in.hcount <= MENU_BTN_X1) &&
                 (vga_btn_in.vcount >= MENU_BTN_Y0) && (vga_btn_in.vcount <= MENU_BTN_Y1);
        on_border = (vga_btn_in.hcount < MENU_BTN_IX0) || (vga_btn_in.hcount > MENU_BTN_IX1) ||
                    (vga_btn_in.vcount < MENU_BTN_IY0) || (vga_btn_in.vcount > MENU_BTN_IY1);
        draw = (btn_st == ACK) || ((btn_st == BLINK) && visible);
        rgb_nxt = vga_btn_in.rgb;
        if (draw && in_box) begin
            if (on_border)
                rgb_nxt = MENU_BTN_BORDER_RGB;
            // Even toggle groups (starting at frame_cnt 0) flash white.
            else if ((btn_st == ACK) && (((frame_cnt / TOGGLE_DIV) & CNT_W'(1)) == '0))
                rgb_nxt = MENU_BTN_FLASH_RGB;
            else
                rgb_nxt = MENU_BTN_FILL_RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_btn_out.hcount <= '0;
            vga_btn_out.vcount <= '0;
            vga_btn_out.hsync  <= 1'b0;
            vga_btn_out.vsync  <= 1'b0;
            vga_btn_out.hblnk  <= 1'b0;
            vga_btn_out.vblnk  <= 1'b0;
            vga_btn_out.rgb    <= '0;
        end else begin
            vga_btn_out.hcount <= vga_btn_in.hcount;
            vga_btn_out.vcount <= vga_btn_in.vcount;
            vga_btn_out.hsync  <= vga_btn_in.hsync;
            vga_btn_out.vsync  <= vga_btn_in.vsync;
            vga_btn_out.hblnk  <= vga_btn_in.hblnk;
            vga_btn_out.vblnk  <= vga_btn_in.vblnk;
            vga_btn_out.rgb    <= rgb_nxt;
        end
    end

endmodule

// File: tb/tb_draw_menu_button.sv
// Scoreboard bench for draw_menu_button using compressed "frames": a few
// probe pixels followed by a short vblank pulse.
module tb_draw_menu_button;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state;
    logic       btn_start;
    logic       start_ack;

    vga_if vin();
    vga_if vout();

    draw_menu_button #(
        .BLINK_FRAMES (30),
        .ACK_FRAMES   (24),
        .ACK_TOGGLE   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .btn_start   (btn_start),
        .start_ack   (start_ack),
        .vga_btn_in  (vin),
        .vga_btn_out (vout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        ack;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         frame_no = 0;
    int         ack_cnt = 0;
    int         ack_frame = -1;
    bit         chk_flag = 1'b0;
    logic [2:0] cur_st = 3'd0;
    logic       cur_btn = 1'b0;

    localparam logic [11:0] C_BORD  = 12'hfa5;
    localparam logic [11:0] C_FILL  = 12'h222;
    localparam logic [11:0] C_FLASH = 12'hfff;
    localparam logic [11:0] C_BG    = 12'h000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        bit   v;
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            v = chk_flag;
            @(negedge clk);
            if (start_ack === 1'b1) begin
                ack_cnt++;
                ack_frame = frame_no;
            end
            if (v) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow: got empty queue expected entry");
                end else begin
                    e = sb.pop_front();
                    a = {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                         vout.hblnk, vout.vblnk, vout.rgb, start_ack};
                    check($sformatf("pix(%0d,%0d) f%0d", e.h, e.v, frame_no), 64'(a), 64'(e));
                end
            end
        end
    endtask

    // One driven cycle; a checked cycle queues the expected output.
    task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] px_rgb,
                       input logic vb, input logic [2:0] st, input logic btn,
                       input bit chk, input logic [11:0] exp_rgb);
        exp_t e;
        @(posedge clk);
        #1;
        vin.hcount = h;
        vin.vcount = v;
        vin.hsync  = h[3];
        vin.vsync  = v[3];
        vin.hblnk  = h[4];
        vin.vblnk  = vb;
        vin.rgb    = px_rgb;
        state      = st;
        btn_start  = btn;
        chk_flag   = chk;
        if (chk) begin
            e = {h, v, h[3], v[3], h[4], vb, exp_rgb, 1'b0};
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        pix(11'd0, 11'd0, 12'h000, 1'b0, cur_st, cur_btn, 1'b0, 12'h000);
    endtask

    task automatic do_reset(input logic [2:0] st, input logic btn);
        cur_st  = st;
        cur_btn = btn;
        rst     = 1'b1;
        repeat (3) pix(11'd500, 11'd330, 12'hfff, 1'b0, cur_st, cur_btn, 1'b0, 12'h000);
        @(negedge clk);
        check("reset_out", 64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                                vout.hblnk, vout.vblnk, vout.rgb}), 64'd0);
        check("reset_ack", 64'(start_ack), 64'd0);
        rst = 1'b0;
        idle();
        frame_no = 0;
        ack_cnt  = 0;
        ack_frame = -1;
    endtask

    task automatic do_frame(input logic [11:0] fill_e, input logic [11:0] bord_e,
                            input bit press, input logic [11:0] post_e, input bit kill);
        pix(11'd420, 11'd330, C_BG, 1'b0, cur_st, cur_btn, 1'b1, fill_e);
        pix(11'd412, 11'd300, C_BG, 1'b0, cur_st, cur_btn, 1'b1, bord_e);
        pix(11'd611, 11'd359, C_BG, 1'b0, cur_st, cur_btn, 1'b1, bord_e);
        pix(11'd418, 11'd306, C_BG, 1'b0, cur_st, cur_btn, 1'b1, fill_e);
        pix(11'd612, 11'd330, 12'h123, 1'b0, cur_st, cur_btn, 1'b1, 12'h123);
        if (press) begin
            pix(11'd100, 11'd100, 12'h456, 1'b0, cur_st, 1'b1, 1'b1, 12'h456);
            pix(11'd100, 11'd101, 12'h456, 1'b0, cur_st, 1'b0, 1'b1, 12'h456);
            cur_btn = 1'b0;
            pix(11'd420, 11'd330, C_BG, 1'b0, cur_st, cur_btn, 1'b1, post_e);
        end
        if (kill) cur_st = 3'd2;
        pix(11'd0, 11'd400, C_BG, 1'b1, cur_st, cur_btn, 1'b0, 12'h000);
        pix(11'd0, 11'd401, C_BG, 1'b1, cur_st, cur_btn, 1'b0, 12'h000);
        pix(11'd0, 11'd0,   C_BG, 1'b0, cur_st, cur_btn, 1'b0, 12'h000);
        frame_no++;
    endtask

    function automatic logic [11:0] ack_fill(input int k);
        return (((k / 4) % 2) == 1) ? C_FILL : C_FLASH;
    endfunction

    initial begin
        bit vis;
        rst       = 1'b1;
        state     = 3'd0;
        btn_start = 1'b0;
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk  = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
        fork
            monitor();
        join_none

        // Blink cadence: 30 visible, 30 hidden, visible again.
        do_reset(3'd0, 1'b0);
        for (int f = 0; f < 70; f++) begin
            vis = (f < 30) || (f >= 60);
            do_frame(vis ? C_FILL : C_BG, vis ? C_BORD : C_BG, 1'b0, C_BG, 1'b0);
        end

        // Press in the hidden phase, flash sequence, acknowledge, box gone.
        do_reset(3'd0, 1'b0);
        for (int f = 0; f < 35; f++) begin
            vis = (f < 30);
            do_frame(vis ? C_FILL : C_BG, vis ? C_BORD : C_BG, 1'b0, C_BG, 1'b0);
        end
        do_frame(C_BG, C_BG, 1'b1, C_FLASH, 1'b0);
        for (int f = 36; f < 59; f++)
            do_frame(ack_fill(f - 35), C_BORD, 1'b0, C_BG, 1'b0);
        check("ack_count", 64'(ack_cnt), 64'd1);
        check("ack_frame", 64'(ack_frame), 64'd58);
        for (int f = 59; f < 62; f++)
            do_frame(C_BG, C_BG, 1'b0, C_BG, 1'b0);
        check("ack_count_after", 64'(ack_cnt), 64'd1);

        // DONE -> OFF, then back to game-over restarts the blink from zero.
        cur_st = 3'd2;
        do_frame(C_BG, C_BG, 1'b0, C_BG, 1'b0);
        cur_st = 3'd6;
        idle();
        frame_no = 0;
        for (int f = 0; f < 31; f++) begin
            vis = (f < 30);
            do_frame(vis ? C_FILL : C_BG, vis ? C_BORD : C_BG, 1'b0, C_BG, 1'b0);
        end

        // Button held through reset and BLINK entry is ignored.
        do_reset(3'd0, 1'b1);
        for (int f = 0; f < 3; f++)
            do_frame(C_FILL, C_BORD, 1'b0, C_BG, 1'b0);
        cur_btn = 1'b0;
        do_frame(C_FILL, C_BORD, 1'b1, C_FLASH, 1'b0);
        do_frame(ack_fill(1), C_BORD, 1'b0, C_BG, 1'b0);
        check("held_ack_count", 64'(ack_cnt), 64'd0);

        // Leaving the menu on the final ACK tick suppresses start_ack.
        do_reset(3'd0, 1'b0);
        do_frame(C_FILL, C_BORD, 1'b1, C_FLASH, 1'b0);
        for (int f = 1; f < 23; f++)
            do_frame(ack_fill(f), C_BORD, 1'b0, C_BG, 1'b0);
        do_frame(ack_fill(23), C_BORD, 1'b0, C_BG, 1'b1);
        do_frame(C_BG, C_BG, 1'b0, C_BG, 1'b0);
        do_frame(C_BG, C_BG, 1'b0, C_BG, 1'b0);
        check("kill_ack_count", 64'(ack_cnt), 64'd0);

        // Latency ramp: state 3 passes everything, state 0 passes outside the box.
        do_reset(3'd3, 1'b0);
        for (int i = 0; i < 40; i++)
            pix(11'(i * 53), 11'(i * 9 + 290), 12'(i * 97 + 5), (i % 5) == 0,
                3'd3, 1'b0, 1'b1, 12'(i * 97 + 5));
        cur_st = 3'd0;
        idle();
        for (int i = 0; i < 40; i++)
            pix(11'(i * 13), 11'(100 + i), 12'(i * 211 + 1), 1'b0,
                3'd0, 1'b0, 1'b1, 12'(i * 211 + 1));

        repeat (3) idle();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
